// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch control stage.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        CLEAR = 2'd3
    } sw_state_t;

    // Number of cycles cnt_nrst is held low when clearing the digit chain.
    localparam int CLR_CYC = 2;

    // Counter width able to hold 0..n-1, never less than one bit.
    function automatic int sw_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_ctrl_if.sv
// Button inputs and digit-chain control outputs of the stopwatch control stage.
// There is no handshake: buttons are raw levels, up is a one-cycle strobe seen only while en=1.
interface sw_ctrl_if;
    import sw_pkg::*;

    logic      btn_ss;
    logic      btn_clr;
    logic      en;
    logic      up;
    logic      cnt_nrst;
    sw_state_t state;
    logic      frz;

    modport master (
        output btn_ss,
        output btn_clr,
        input  en,
        input  up,
        input  cnt_nrst,
        input  state,
        input  frz
    );

    modport slave (
        input  btn_ss,
        input  btn_clr,
        output en,
        output up,
        output cnt_nrst,
        output state,
        output frz
    );

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser, debounce counter and single-cycle press pulse for one button.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int DB_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = sw_clog2(DB_CYC);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_synced;
    logic          w_done;

    assign w_synced = r_sync[1];
    // The counter only runs while a change is pending; it commits once stable for DB_CYC cycles.
    assign w_done   = (w_synced != r_level) && (r_cnt == CW'(DB_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= w_done & w_synced;
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control: debounced buttons, IDLE/RUN/PAUSE/CLEAR FSM and TICK_HZ prescaler.
// Define SW_LAP_HOLD_EN to enable the lap-hold display freeze (frz) toggled by clr in RUN.
module sw_ctrl
    import sw_pkg::*;
#(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 100,
    parameter int DB_MS   = 10
) (
    input  logic    clk,
    input  logic    rst,
    sw_ctrl_if.slave bus
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int DB_CYC = CLK_HZ / 1000 * DB_MS;
    localparam int PW     = sw_clog2(DIV);

    sw_state_t     r_state;
    sw_state_t     w_state_nx;
    logic          r_en;
    logic          r_cnt_nrst;
    logic          r_clr_cnt;
    logic          w_clr_cnt_nx;
    logic [PW-1:0] r_pc;
    logic [PW-1:0] w_pc_nx;
    logic          w_ss_press;
    logic          w_clr_press;
    logic          w_tick;

    sw_debounce #(.DB_CYC(DB_CYC)) u_db_ss (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_ss),
        .o_press (w_ss_press)
    );

    sw_debounce #(.DB_CYC(DB_CYC)) u_db_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_clr),
        .o_press (w_clr_press)
    );

    assign w_tick = (r_state == RUN) && (r_pc == PW'(DIV - 1));

    always_comb begin
        w_state_nx   = r_state;
        w_clr_cnt_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clr_press) begin
                    w_state_nx = CLEAR;
                end else if (w_ss_press) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (w_ss_press) begin
                    w_state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (w_clr_press) begin
                    w_state_nx = CLEAR;
                end else if (w_ss_press) begin
                    w_state_nx = RUN;
                end
            end
            CLEAR: begin
                // Presses are ignored here; the chain is held in clear for CLR_CYC cycles.
                if (r_clr_cnt == 1'(CLR_CYC - 1)) begin
                    w_state_nx = IDLE;
                end else begin
                    w_clr_cnt_nx = r_clr_cnt + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Prescaler keeps its phase across PAUSE so resume neither loses nor adds a tick.
    always_comb begin
        w_pc_nx = '0;
        case (r_state)
            RUN:     w_pc_nx = w_tick ? '0 : r_pc + PW'(1);
            PAUSE:   w_pc_nx = r_pc;
            default: w_pc_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_cnt_nrst <= 1'b0;
            r_clr_cnt  <= 1'b0;
            r_pc       <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_en       <= (w_state_nx == RUN);
            r_cnt_nrst <= (w_state_nx != CLEAR);
            r_clr_cnt  <= w_clr_cnt_nx;
            r_pc       <= w_pc_nx;
        end
    end

`ifdef SW_LAP_HOLD_EN
    logic r_frz;
    logic w_frz_nx;

    always_comb begin
        w_frz_nx = r_frz;
        if (r_state == RUN && w_state_nx == RUN && w_clr_press) begin
            w_frz_nx = ~r_frz;
        end
        if (w_state_nx != RUN) begin
            w_frz_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frz <= 1'b0;
        end else begin
            r_frz <= w_frz_nx;
        end
    end

    assign bus.frz = r_frz;
`else
    assign bus.frz = 1'b0;
`endif

    assign bus.en       = r_en;
    assign bus.up       = w_tick;
    assign bus.cnt_nrst = r_cnt_nrst;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_sw_ctrl.sv
// Directed bench for sw_ctrl (CLK_HZ=1000, TICK_HZ=100, DB_MS=2 -> DIV=10, DB_CYC=2).
// Every output change or up pulse is an event checked in order, including the cycle gap since the previous event.
module tb_sw_ctrl;
    import sw_pkg::*;

    logic clk;
    logic rst;
    logic mon_en;
    int   checks;
    int   failures;
    int   cyc;
    int   last_cyc;
    int   ev_num;

    logic [13:0] exp_q[$];
    logic [5:0]  prev_obs;

    sw_ctrl_if bus ();

    sw_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .DB_MS   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic exp_ev(input int gap, input sw_state_t st, input logic en,
                          input logic up, input logic nrst, input logic frz);
        logic [7:0] g;
        g = 8'(gap);
        exp_q.push_back({g, st, en, up, nrst, frz});
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [5:0]  obs;
        logic [13:0] got;
        logic [13:0] want;
        logic [7:0]  gap;
        cyc = cyc + 1;
        obs = {bus.state, bus.en, bus.up, bus.cnt_nrst, bus.frz};
        if (mon_en) begin
            if (({obs[5:3], obs[1:0]} != {prev_obs[5:3], prev_obs[1:0]}) || obs[2]) begin
                gap = 8'(cyc - last_cyc);
                got = {gap, obs};
                ev_num = ev_num + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL event%0d unexpected gap=%0d st/en/up/nrst/frz=%b", ev_num, gap, obs);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures = failures + 1;
                        $display("FAIL event%0d got gap=%0d st/en/up/nrst/frz=%b expected gap=%0d st/en/up/nrst/frz=%b",
                                 ev_num, got[13:6], got[5:0], want[13:6], want[5:0]);
                    end
                end
                last_cyc = cyc;
            end
        end else begin
            last_cyc = cyc;
        end
        prev_obs = obs;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        mon_en      = 1'b0;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        last_cyc    = 0;
        ev_num      = 0;
        prev_obs    = '0;
        bus.btn_ss  = 1'b0;
        bus.btn_clr = 1'b0;

        // Expected event sequence; gaps are cycles since the previous event.
        exp_ev(2,  IDLE,  1'b0, 1'b0, 1'b1, 1'b0);  // cnt_nrst rises first edge after release
        exp_ev(7,  RUN,   1'b1, 1'b0, 1'b1, 1'b0);  // ss press: 2+DB_CYC, then FSM edge
        exp_ev(9,  RUN,   1'b1, 1'b1, 1'b1, 1'b0);  // first tick on 10th RUN cycle
        for (int i = 0; i < 5; i++) begin
            exp_ev(10, RUN, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        exp_ev(4,  PAUSE, 1'b0, 1'b0, 1'b1, 1'b0);  // pauses with pc=3
        exp_ev(14, RUN,   1'b1, 1'b0, 1'b1, 1'b0);  // resume
        exp_ev(6,  RUN,   1'b1, 1'b1, 1'b1, 1'b0);  // 7th RUN cycle after resume
        exp_ev(7,  PAUSE, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ev(12, CLEAR, 1'b0, 1'b0, 1'b0, 1'b0);  // clr beats ss in PAUSE
        exp_ev(2,  IDLE,  1'b0, 1'b0, 1'b1, 1'b0);  // cnt_nrst low exactly 2 cycles
        exp_ev(13, RUN,   1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SW_LAP_HOLD_EN
        exp_ev(6,  RUN,   1'b1, 1'b0, 1'b1, 1'b1);  // lap freeze
        exp_ev(3,  RUN,   1'b1, 1'b1, 1'b1, 1'b1);  // counting continues under freeze
`else
        exp_ev(9,  RUN,   1'b1, 1'b1, 1'b1, 1'b0);  // clr in RUN ignored, pc restarted from 0
`endif
        exp_ev(3,  IDLE,  1'b0, 1'b0, 1'b0, 1'b0);  // async reset mid-RUN
        exp_ev(4,  IDLE,  1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_state0", bus.state[0], 1'b0);
        check_bit("reset_state1", bus.state[1], 1'b0);
        check_bit("reset_en", bus.en, 1'b0);
        check_bit("reset_up", bus.up, 1'b0);
        check_bit("reset_cnt_nrst", bus.cnt_nrst, 1'b0);
        check_bit("reset_frz", bus.frz, 1'b0);

        @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        step(3);  bus.btn_ss = 1'b1;          // start
        step(6);  bus.btn_ss = 1'b0;
        step(11); bus.btn_ss = 1'b1;          // one-cycle glitch
        step(1);  bus.btn_ss = 1'b0;
        step(45); bus.btn_ss = 1'b1;          // pause
        step(4);  bus.btn_ss = 1'b0;
        step(10); bus.btn_ss = 1'b1;          // resume
        step(4);  bus.btn_ss = 1'b0;
        step(9);  bus.btn_ss = 1'b1;          // pause again
        step(4);  bus.btn_ss = 1'b0;
        step(8);  bus.btn_ss = 1'b1; bus.btn_clr = 1'b1;  // simultaneous in PAUSE
        step(4);  bus.btn_ss = 1'b0; bus.btn_clr = 1'b0;
        step(11); bus.btn_ss = 1'b1;          // start from cleared state
        step(4);  bus.btn_ss = 1'b0;
        step(2);  bus.btn_clr = 1'b1;         // clr while running
        step(4);  bus.btn_clr = 1'b0;
        step(7);  rst = 1'b1;                 // reset mid-RUN
        step(3);  rst = 1'b0;
        step(15);

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL missing_events got=%0d events still pending expected=0", exp_q.size());
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
